// File: rtl/synapse_accumulator_if.sv
// Handshake and data bundle between the spike source and the accumulator.
// Master drives weights, spikes and step requests; slave returns the result.
interface synapse_accumulator_if #(
  parameter int NUM_INPUTS   = 8,
  parameter int ADDR_WIDTH   = 3,
  parameter int WEIGHT_WIDTH = 6,
  parameter int OUT_WIDTH    = 8
);
  logic                    weight_wr_en;
  logic [ADDR_WIDTH-1:0]   weight_wr_addr;
  logic [WEIGHT_WIDTH-1:0] weight_wr_data;
  logic [NUM_INPUTS-1:0]   spike_in;
  logic                    step_start;
  logic                    busy;
  logic [OUT_WIDTH-1:0]    synaptic_input;
  logic                    synaptic_valid;

  modport master (
    output weight_wr_en,
    output weight_wr_addr,
    output weight_wr_data,
    output spike_in,
    output step_start,
    input  busy,
    input  synaptic_input,
    input  synaptic_valid
  );

  modport slave (
    input  weight_wr_en,
    input  weight_wr_addr,
    input  weight_wr_data,
    input  spike_in,
    input  step_start,
    output busy,
    output synaptic_input,
    output synaptic_valid
  );
endinterface

// File: rtl/synapse_accumulator.sv
// Serial weighted spike accumulator feeding the LIF neuron.
// One input per clock, saturating sum, one-cycle result strobe.
module synapse_accumulator #(
  parameter int NUM_INPUTS   = 8,
  parameter int ADDR_WIDTH   = 3,
  parameter int WEIGHT_WIDTH = 6,
  parameter int OUT_WIDTH    = 8
) (
  input logic clk,
  input logic reset,
  synapse_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
    ADDR_WIDTH'(NUM_INPUTS - 1);

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [OUT_WIDTH-1:0]    acc_q, acc_d;
  logic [NUM_INPUTS-1:0]   snap_q, snap_d;
  logic [WEIGHT_WIDTH-1:0] weight_q [NUM_INPUTS];
  logic [WEIGHT_WIDTH-1:0] weight_d [NUM_INPUTS];
  logic [OUT_WIDTH-1:0]    out_q, out_d;
  logic                    valid_q, valid_d;

  logic                    last;
  logic                    addr_ok;
  logic [OUT_WIDTH:0]      sum_wide;
  logic [OUT_WIDTH-1:0]    acc_sat;
  logic [OUT_WIDTH-1:0]    acc_next;

  // Out-of-range write addresses only exist when the
  // address space is larger than the weight file.
  if ((1 << ADDR_WIDTH) > NUM_INPUTS) begin : g_addr_chk
    assign addr_ok =
      {1'b0, bus.weight_wr_addr} <
      (ADDR_WIDTH + 1)'(NUM_INPUTS);
  end else begin : g_addr_full
    assign addr_ok = 1'b1;
  end

  // Saturating add of the current weight; one bit of headroom.
  always_comb begin
    last     = (idx_q == LAST_IDX);
    sum_wide = (OUT_WIDTH + 1)'(acc_q) +
               (OUT_WIDTH + 1)'(weight_q[idx_q]);
    acc_sat  = sum_wide[OUT_WIDTH] ? '1 :
               sum_wide[OUT_WIDTH-1:0];
    acc_next = snap_q[idx_q] ? acc_sat : acc_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; requests while busy are dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.step_start) state_d = ACCUM;
      ACCUM:   if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: result registered on the last accumulate edge.
  always_comb begin
    valid_d = (state_q == ACCUM) && last;
    out_d   = valid_d ? acc_next : '0;
  end

  assign bus.busy           = (state_q != IDLE);
  assign bus.synaptic_input = out_q;
  assign bus.synaptic_valid = valid_q;

  // Datapath next values: snapshot, index walk, accumulator.
  always_comb begin
    snap_d = snap_q;
    acc_d  = acc_q;
    idx_d  = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.step_start) begin
          snap_d = bus.spike_in;
          acc_d  = '0;
          idx_d  = '0;
        end
      end
      ACCUM: begin
        acc_d = acc_next;
        idx_d = last ? '0 : idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Weight file write; the read of index k sees the old value.
  always_comb begin
    weight_d = weight_q;
    if (bus.weight_wr_en && addr_ok) begin
      weight_d[bus.weight_wr_addr] = bus.weight_wr_data;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q    <= '0;
      acc_q    <= '0;
      snap_q   <= '0;
      weight_q <= '{default: '0};
      out_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      snap_q   <= snap_d;
      weight_q <= weight_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_synapse_accumulator.sv
// Directed bench for synapse_accumulator.
// Vector table plus hand sequences for busy, reset and write races.
module tb_synapse_accumulator;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int WW = 6;
  localparam int OW = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  synapse_accumulator_if #(
    .NUM_INPUTS(N), .ADDR_WIDTH(AW),
    .WEIGHT_WIDTH(WW), .OUT_WIDTH(OW)
  ) bus ();

  synapse_accumulator #(
    .NUM_INPUTS(N), .ADDR_WIDTH(AW),
    .WEIGHT_WIDTH(WW), .OUT_WIDTH(OW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] spikes;
    int         wbase;
    int         wstep;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic wr(input int a, input int d);
    bus.weight_wr_en   = 1'b1;
    bus.weight_wr_addr = AW'(a);
    bus.weight_wr_data = WW'(d);
    @(negedge clk);
    bus.weight_wr_en   = 1'b0;
  endtask

  task automatic load(input int base, input int stp);
    for (int i = 0; i < N; i++) wr(i, base + stp * i);
  endtask

  task automatic run_step(input logic [7:0] sp,
                          input logic [7:0] exp,
                          input string tag);
    bus.spike_in   = sp;
    bus.step_start = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (j == 1) begin
        bus.step_start = 1'b0;
        bus.spike_in   = ~sp;
      end
      chk({tag, " busy"}, 32'(bus.busy), 32'(j <= 9));
      chk({tag, " valid"}, 32'(bus.synaptic_valid),
          32'(j == 9));
      chk({tag, " data"}, 32'(bus.synaptic_input),
          (j == 9) ? 32'(exp) : 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1, 1, 8'd18, "basic"};
    vecs[1] = '{8'hFF, 63, 0, 8'd255, "sat_all"};
    vecs[2] = '{8'h00, 1, 1, 8'd0, "no_spikes"};
    vecs[3] = '{8'hFF, 1, 1, 8'd36, "all_ramp"};
    vecs[4] = '{8'h80, 63, 0, 8'd63, "top_only"};
    vecs[5] = '{8'h0F, 10, 5, 8'd70, "low_nib"};
    vecs[6] = '{8'hF0, 10, 5, 8'd150, "high_nib"};
    vecs[7] = '{8'h1F, 51, 0, 8'd255, "exact_max"};
    vecs[8] = '{8'h0F, 63, 0, 8'd252, "near_max"};

    reset              = 1'b1;
    bus.step_start     = 1'b1;
    bus.spike_in       = 8'hFF;
    bus.weight_wr_en   = 1'b0;
    bus.weight_wr_addr = '0;
    bus.weight_wr_data = '0;

    repeat (2) begin
      @(negedge clk);
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset valid", 32'(bus.synaptic_valid), 32'd0);
      chk("reset data", 32'(bus.synaptic_input), 32'd0);
    end
    reset          = 1'b0;
    bus.step_start = 1'b0;
    run_step(8'hFF, 8'd0, "post_reset");

    for (int v = 0; v < 9; v++) begin
      load(vecs[v].wbase, vecs[v].wstep);
      run_step(vecs[v].spikes, vecs[v].exp, vecs[v].name);
    end

    // step_start held for 20 edges while spikes toggle
    load(1, 1);
    bus.spike_in   = 8'hA5;
    bus.step_start = 1'b1;
    for (int j = 1; j <= 21; j++) begin
      @(negedge clk);
      chk("hold busy", 32'(bus.busy),
          32'(!(j == 10 || j >= 20)));
      chk("hold valid", 32'(bus.synaptic_valid),
          32'(j == 9 || j == 19));
      chk("hold data", 32'(bus.synaptic_input),
          (j == 9) ? 32'd18 : (j == 19) ? 32'd10 : 32'd0);
      if (j == 10) bus.spike_in = 8'h0F;
      else bus.spike_in = (j % 2 == 1) ? 8'hFF : 8'hF0;
      if (j == 20) bus.step_start = 1'b0;
    end

    // reset sampled at edge T+4 of a running step
    bus.spike_in   = 8'hFF;
    bus.step_start = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j == 1) bus.step_start = 1'b0;
      chk("midrst busy", 32'(bus.busy), 32'(j <= 4));
      chk("midrst valid", 32'(bus.synaptic_valid), 32'd0);
      chk("midrst data", 32'(bus.synaptic_input), 32'd0);
      if (j == 4) reset = 1'b1;
      if (j == 5) reset = 1'b0;
    end
    run_step(8'hFF, 8'd0, "after_midrst");

    // weight writes racing the serial read
    load(1, 0);
    bus.spike_in   = 8'hFF;
    bus.step_start = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      chk("race busy", 32'(bus.busy), 32'(j <= 9));
      chk("race valid", 32'(bus.synaptic_valid),
          32'(j == 9));
      chk("race data", 32'(bus.synaptic_input),
          (j == 9) ? 32'd17 : 32'd0);
      if (j == 1) begin
        bus.step_start     = 1'b0;
        bus.weight_wr_en   = 1'b1;
        bus.weight_wr_addr = 3'd0;
        bus.weight_wr_data = 6'd20;
      end
      if (j == 2) begin
        bus.weight_wr_addr = 3'd3;
        bus.weight_wr_data = 6'd10;
      end
      if (j == 3) bus.weight_wr_en = 1'b0;
    end
    run_step(8'hFF, 8'd36, "race_next");

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/synapse_accumulator.md
Name: synapse_accumulator

Overview:
- Upstream stage of the LIF neuron. Once per neuron timestep, it turns a vector of presynaptic spikes into one weighted synaptic current word.
- Holds a per-input unsigned weight register file.
- On a step request it snapshots the spike vector and sums the weights of the active inputs serially, one input per clock, with saturation.
- It drives `synaptic_input` for exactly one cycle, so the downstream neuron integrates each step exactly once.

Parameters:
- NUM_INPUTS, 8: number of presynaptic inputs (>= 2).
- ADDR_WIDTH, 3: weight address width; 2^ADDR_WIDTH >= NUM_INPUTS.
- WEIGHT_WIDTH, 6: unsigned weight width.
- OUT_WIDTH, 8: width of `synaptic_input`; matches the neuron's membrane potential width.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- weight_wr_en  input  1  weight write strobe.
- weight_wr_addr  input  ADDR_WIDTH  weight index to write.
- weight_wr_data  input  WEIGHT_WIDTH  unsigned weight value.
- spike_in  input  NUM_INPUTS  presynaptic spike vector; bit i is input i.
- step_start  input  1  request one accumulation step.
- busy  output  1  high while a step is in progress (state != IDLE).
- synaptic_input  output  OUT_WIDTH  weighted sum; nonzero only in the valid cycle.
- synaptic_valid  output  1  one-cycle strobe marking the result.

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high, sampled on the rising edge of `clk`.
- Reset (synchronous, any state, including mid-step):
  - state=IDLE, index=0, accumulator=0.
  - All weights=0, spike snapshot=0.
  - busy=0, synaptic_input=0, synaptic_valid=0.
  - An in-flight step is discarded; no valid strobe is produced.
- Weight writes:
  - Accepted in any state when weight_wr_en=1. Registered at the clock edge.
  - Addresses >= NUM_INPUTS are ignored.
  - Writes never stall and never affect busy.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - step_start=1 at edge T: latch spike_in into the snapshot, clear the accumulator, index=0, go to ACCUM.
  - synaptic_input=0, synaptic_valid=0.
- ACCUM (cycles T+1 .. T+NUM_INPUTS, one index per cycle):
  - If snapshot[index]=1, accumulator <= sat(accumulator + weight[index]).
  - The sum is computed at OUT_WIDTH+1 bits and clamped to 2^OUT_WIDTH-1.
  - Weights are zero-extended.
  - index increments each cycle. When index=NUM_INPUTS-1 is processed, go to DONE, and at that same edge register synaptic_input=final sum and synaptic_valid=1.
- DONE (cycle T+NUM_INPUTS+1):
  - synaptic_valid=1 and synaptic_input=sum for exactly this cycle.
  - Next edge: go to IDLE, synaptic_input=0, synaptic_valid=0.
- Latency:
  - step_start sampled at edge T gives the valid strobe in cycle T+NUM_INPUTS+1.
  - The next step_start is accepted at edge T+NUM_INPUTS+2 at the earliest, giving one step per NUM_INPUTS+2 cycles.
- step_start while busy (ACCUM or DONE): ignored; it is not queued.
- spike_in changes after the snapshot edge have no effect on the current step.
- Weight write in the same cycle that index k is read:
  - The old weight[k] is used.
  - A write to an index j > current index takes effect for this step.
  - A write to an index j < current index affects only later steps.
- Zero active spikes still complete the step and produce valid=1 with synaptic_input=0.

Test Plan:
- Reset: assert reset for 2 cycles with spike_in=all-ones and step_start=1 → busy=0, synaptic_valid=0, synaptic_input=0 throughout; after release, a step with all spikes gives sum 0 (weights cleared).
- Basic sum:
  - Stimulus: weights[i]=i+1 for i=0..7; spike_in=8'b1010_0101; step_start at edge T.
  - Required: valid only in cycle T+9 with synaptic_input=18 (1+3+6+8); synaptic_input=0 in all other cycles; busy high in T+1..T+9.
- Saturation: all weights=63, spike_in=8'hFF → synaptic_input=255 (not 504 mod 256=248), valid for one cycle.
- Busy rules:
  - Stimulus: step_start held high for 20 cycles; spike_in toggled during ACCUM.
  - Required: valid pulses at T+9 and T+19 only; each sum reflects the spike_in sampled at its accepting edge.
- Reset mid-step: reset at cycle T+4 of a step → no valid strobe; outputs 0; next step after release produces the correct sum with all weights 0.
- Write during ACCUM:
  - Stimulus: weights=1, spike_in=8'hFF; during cycle T+1 (index 0) write addr 3=10 and addr 0=20.
  - Required: result=17 (the addr 3 write is used; the addr 0 write is not); a following step yields 36.
